// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and default divisor.
// Helper functions keep the parity rule in one place for the transmitter and a future receiver.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // 100 MHz system clock at 9600 baud
   localparam int DEFAULT_CLKS_PER_BIT = 10417;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Word is zero-extended to 9 bits, which leaves the XOR unchanged.
   function automatic logic parity_bit(input logic [1:0] mode, input logic [8:0] word);
      return (^word) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO with occupancy count and asynchronous active-low reset.
// A push while full is accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO front end, LSB-first serialiser with optional parity
// and one or two stop bits, frames sent back-to-back while words are queued.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         data,
   input  logic                          data_valid,
   output logic                          data_ready,
   input  logic [1:0]                    parity_mode,
   input  logic                          two_stop,
   output logic                          tx,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output tx_state_t                     dbg_state
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W  = $clog2(DATA_WIDTH);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   tx_state_t               r_state;
   logic [BAUD_W-1:0]       r_baud;
   logic [IDX_W-1:0]        r_bit_idx;
   logic [DATA_WIDTH-1:0]   r_shift;
   logic                    r_par_en;
   logic                    r_par_bit;
   logic                    r_two_stop;
   logic                    r_stop_idx;
   logic                    r_tx;
   logic                    r_done;
   logic                    r_rdy_en;

   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [DATA_WIDTH-1:0]   w_fifo_data;
   logic [8:0]              w_word_ext;
   logic                    w_bit_end;
   logic                    w_final_stop;
   logic                    w_frame_end;

   uart_tx_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   always_comb begin
      w_word_ext = '0;
      w_word_ext[DATA_WIDTH-1:0] = w_fifo_data;
   end

   assign w_bit_end    = (r_baud == BAUD_LAST);
   assign w_final_stop = (r_state == ST_STOP) && (!r_two_stop || r_stop_idx);
   assign w_frame_end  = w_final_stop && w_bit_end;
   assign w_pop        = !w_empty && ((r_state == ST_IDLE) || w_frame_end);
   // A slot freed by this edge's pop may be refilled on the same edge.
   assign data_ready   = r_rdy_en & (~w_full | w_pop);
   assign w_push       = data_valid & data_ready;

   assign tx        = r_tx;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign dbg_state = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_two_stop <= 1'b0;
         r_stop_idx <= 1'b0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         // Raised one cycle early so done is high on the final stop-bit cycle.
         r_done <= w_final_stop && (r_baud == BAUD_PRE);
         if (w_pop) begin
            r_state    <= ST_START;
            r_baud     <= '0;
            r_tx       <= 1'b0;
            r_shift    <= w_fifo_data;
            r_par_en   <= parity_enabled(parity_mode);
            r_par_bit  <= parity_bit(parity_mode, w_word_ext);
            r_two_stop <= two_stop;
            r_stop_idx <= 1'b0;
            r_bit_idx  <= '0;
         end else if (r_state == ST_IDLE) begin
            r_baud <= '0;
            r_tx   <= 1'b1;
         end else if (!w_bit_end) begin
            r_baud <= r_baud + 1'b1;
         end else begin
            r_baud <= '0;
            case (r_state)
               ST_START: begin
                  r_state   <= ST_DATA;
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_idx <= '0;
               end
               ST_DATA: begin
                  if (r_bit_idx == IDX_LAST) begin
                     if (r_par_en) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_par_bit;
                     end else begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
               ST_PARITY: begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
               end
               ST_STOP: begin
                  if (w_final_stop) begin
                     r_state <= ST_IDLE;
                     r_tx    <= 1'b1;
                  end else begin
                     r_stop_idx <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: reset, 8N1, parity, burst/full FIFO,
// two stop bits with mid-frame config change, and reset mid-frame.
module tb_uart_tx_param;
   import uart_pkg::*;

   localparam int DW  = 8;
   localparam int CPB = 16;
   localparam int FD  = 4;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] data;
   logic          data_valid;
   logic          data_ready;
   logic [1:0]    parity_mode;
   logic          two_stop;
   logic          tx;
   logic          busy;
   logic          done;
   logic [2:0]    fifo_count;
   tx_state_t     dbg_state;

   int checks;
   int errors;

   uart_tx_param #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data        (data),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .parity_mode (parity_mode),
      .two_stop    (two_stop),
      .tx          (tx),
      .busy        (busy),
      .done        (done),
      .fifo_count  (fifo_count),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver: present one word and wait (bounded) for the handshake edge
   task automatic write_word(input logic [DW-1:0] w);
      int t;
      data       = w;
      data_valid = 1'b1;
      t = 0;
      while (data_ready !== 1'b1 && t < 400) begin
         tick();
         t++;
      end
      check("wr_ready", data_ready, 1);
      tick();
      data_valid = 1'b0;
   endtask

   // Called just after the start-bit edge; returns on the frame's last cycle.
   task automatic run_frame(input logic [7:0] w, input bit par_en, input bit par_b,
                            input int nstop, input int toggle_at, input string tag);
      logic exp_bits [12];
      int   nb;
      int   edge_err;
      int   busy_err;
      int   done_cnt;
      int   done_at;
      exp_bits[0] = 1'b0;
      for (int j = 0; j < 8; j++) exp_bits[1 + j] = w[j];
      nb = 9;
      if (par_en) begin
         exp_bits[nb] = par_b;
         nb = nb + 1;
      end
      for (int s = 0; s < nstop; s++) begin
         exp_bits[nb] = 1'b1;
         nb = nb + 1;
      end
      edge_err = 0;
      busy_err = 0;
      done_cnt = 0;
      done_at  = -1;
      for (int i = 0; i < nb * CPB; i++) begin
         if (i == toggle_at) begin
            parity_mode = PAR_NONE;
            two_stop    = 1'b0;
         end
         if ((i % CPB) == 0 || (i % CPB) == CPB - 1) begin
            if (tx !== exp_bits[i / CPB]) edge_err++;
         end
         if ((i % CPB) == CPB / 2) begin
            check($sformatf("%s_bit%0d", tag, i / CPB), tx, exp_bits[i / CPB]);
         end
         if (busy !== 1'b1) busy_err++;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = i;
         end
         if (i < nb * CPB - 1) tick();
      end
      check({tag, "_bit_edges"}, edge_err, 0);
      check({tag, "_busy"}, busy_err, 0);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_at"}, done_at, nb * CPB - 1);
   endtask

   initial begin
      logic [7:0] burst [6];
      logic [7:0] rx;
      int busy_err;
      int done_cnt;
      int done_bad;
      int gap_err;
      int idle_err;

      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      data        = '0;
      data_valid  = 1'b0;
      parity_mode = PAR_NONE;
      two_stop    = 1'b0;

      // 1. reset
      repeat (3) tick();
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", data_ready, 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", data_ready, 1);
      check("post_rst_state", dbg_state, ST_IDLE);

      // 2. 8N1 frame of 8'hEC
      write_word(8'hEC);
      check("8n1_pre_busy", busy, 0);
      check("8n1_pre_count", fifo_count, 1);
      tick();
      check("8n1_latency_busy", busy, 1);
      check("8n1_latency_count", fifo_count, 0);
      run_frame(8'hEC, 1'b0, 1'b0, 1, -1, "8n1");
      tick();
      check("8n1_end_busy", busy, 0);
      check("8n1_end_tx", tx, 1);
      check("8n1_end_done", done, 0);

      // 3. parity even then odd on 8'h6D
      parity_mode = PAR_EVEN;
      write_word(8'h6D);
      tick();
      run_frame(8'h6D, 1'b1, 1'b1, 1, -1, "par_even");
      tick();
      check("par_even_end_busy", busy, 0);
      parity_mode = PAR_ODD;
      write_word(8'h6D);
      tick();
      run_frame(8'h6D, 1'b1, 1'b0, 1, -1, "par_odd");
      tick();
      check("par_odd_end_busy", busy, 0);

      // 4. burst of six words into a four-deep FIFO
      parity_mode = PAR_NONE;
      burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'hA5;
      burst[3] = 8'h3C; burst[4] = 8'hF0; burst[5] = 8'h5A;
      data_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         data = burst[n];
         check($sformatf("burst_ready%0d", n), data_ready, 1);
         tick();
      end
      check("burst_full_ready", data_ready, 0);
      check("burst_full_count", fifo_count, 4);
      data = burst[5];
      busy_err = 0;
      done_cnt = 0;
      done_bad = 0;
      gap_err  = 0;
      rx       = '0;
      for (int c = 3; c < 6 * 160; c++) begin
         int p;
         int pos;
         int off;
         p   = c % 160;
         pos = p / CPB;
         off = p % CPB;
         if (busy !== 1'b1) busy_err++;
         if (done === 1'b1) begin
            if (p == 159) done_cnt++;
            else done_bad++;
         end
         if (p == 0 && tx !== 1'b0) gap_err++;
         if (off == CPB / 2 && pos >= 1 && pos <= 8) rx[pos - 1] = tx;
         if (off == CPB / 2 && pos == 9 && tx !== 1'b1) gap_err++;
         if (p == 159) check($sformatf("burst_word%0d", c / 160), rx, burst[c / 160]);
         if (c == 158) check("burst_still_full", data_ready, 0);
         if (c == 159) begin
            check("burst_pop_edge_ready", data_ready, 1);
            check("burst_pop_edge_count", fifo_count, 4);
         end
         if (c == 160) begin
            check("burst_push6_count", fifo_count, 4);
            check("burst_push6_ready", data_ready, 0);
            data_valid = 1'b0;
         end
         if (c < 6 * 160 - 1) tick();
      end
      check("burst_busy", busy_err, 0);
      check("burst_done_cnt", done_cnt, 6);
      check("burst_done_misplaced", done_bad, 0);
      check("burst_gap", gap_err, 0);
      tick();
      check("burst_end_busy", busy, 0);
      check("burst_end_count", fifo_count, 0);

      // 5. two stop bits, odd parity, config toggled mid-frame
      parity_mode = PAR_ODD;
      two_stop    = 1'b1;
      write_word(8'h00);
      tick();
      run_frame(8'h00, 1'b1, 1'b1, 2, 50, "stop2");
      tick();
      check("stop2_end_busy", busy, 0);
      parity_mode = PAR_NONE;
      two_stop    = 1'b0;

      // 6. reset in the middle of a frame with words queued
      write_word(8'h81);
      write_word(8'h42);
      write_word(8'h24);
      done_cnt = 0;
      for (int c = 1; c < 50; c++) begin
         if (done === 1'b1) done_cnt++;
         tick();
      end
      check("midrst_pre_count", fifo_count, 2);
      check("midrst_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_count", fifo_count, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_ready", data_ready, 0);
      tick();
      tick();
      rst_n = 1'b1;
      idle_err = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) idle_err++;
         if (done === 1'b1) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 0);
      check("midrst_idle", idle_err, 0);
      check("midrst_ready_after", data_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
